// File: rtl/hx8352_init_sequencer_if.sv
// 16-bit 8080-style write bus from the init sequencer to the HX8352 panel.
//
// Handshake: there is no backpressure on this bus. A write is transferred
// when lcd_cs_n is low and lcd_wr_n rises; lcd_rs and lcd_data are stable
// from at least one clock before lcd_wr_n falls until after it rises.
// lcd_rd_n is never asserted.
interface hx8352_init_sequencer_if;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [15:0] lcd_data;

  modport master (
    output lcd_cs_n,
    output lcd_rs,
    output lcd_wr_n,
    output lcd_rd_n,
    output lcd_data
  );

  modport slave (
    input lcd_cs_n,
    input lcd_rs,
    input lcd_wr_n,
    input lcd_rd_n,
    input lcd_data
  );
endinterface

// File: rtl/hx8352_init_sequencer.sv
// HX8352 register-init sequencer. Once the panel hardware reset is done it
// walks a small init ROM (command writes, data writes, millisecond delays)
// on the 8080 bus, then raises init_done for the GRAM writer downstream.
//
// Init ROM layout: 0 CMD 0x0083, 1 DATA 0x0002, 2 DELAY 5, 3 CMD 0x0085,
// 4 DATA 0x0003, 5 CMD 0x0022 (GRAM write), 6 END; every later entry is END.
// With TEST_NO_END set, entries from 6 onward become DATA 0xA000|index so
// the table has no END and the last-index stop is exercised.
// All bus outputs are registered. wr_n follows the WR_LO state one clock
// later, which yields one cycle of data setup before the falling edge and
// keeps data/rs stable past the rising edge. ROM_DEPTH must be at least 8.
module hx8352_init_sequencer #(
  parameter int WR_LOW_CYCLES     = 2,
  parameter int WR_HIGH_CYCLES    = 2,
  parameter int DELAY_UNIT_CYCLES = 50_000,
  parameter int ROM_DEPTH         = 64,
  parameter bit TEST_NO_END       = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_tick,
  input  logic                           lcd_rst_done,
  hx8352_init_sequencer_if.master        lcd,
  output logic                           busy,
  output logic                           init_done,
  output logic [2:0]                     state_dbg
);

  localparam int IDX_W = $clog2(ROM_DEPTH);

  localparam logic [1:0] T_CMD   = 2'd0;
  localparam logic [1:0] T_DATA  = 2'd1;
  localparam logic [1:0] T_DELAY = 2'd2;
  localparam logic [1:0] T_END   = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DELAY = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [23:0]      WR_LO_LOAD = 24'(WR_LOW_CYCLES - 1);
  localparam logic [23:0]      WR_HI_LOAD = 24'(WR_HIGH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(ROM_DEPTH - 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [17:0]      rom_q;
  logic [23:0]      cnt;
  logic             cs_n_q;
  logic             rs_q;
  logic             wr_n_q;
  logic [15:0]      data_q;
  logic [47:0]      dly_prod;
  logic [23:0]      dly_load;
  logic             active;
  logic             abort;

  // Init ROM contents, entry = {type[1:0], value[15:0]}.
  function automatic logic [17:0] rom_entry(input logic [IDX_W-1:0] i);
    logic [17:0] e;
    case (int'(i))
      0:       e = {T_CMD,   16'h0083};
      1:       e = {T_DATA,  16'h0002};
      2:       e = {T_DELAY, 16'd5};
      3:       e = {T_CMD,   16'h0085};
      4:       e = {T_DATA,  16'h0003};
      5:       e = {T_CMD,   16'h0022};
      default: e = TEST_NO_END ? {T_DATA, 16'hA000 | 16'(i)} : {T_END, 16'h0000};
    endcase
    return e;
  endfunction

  // Delay length in clocks, clamped to the 24-bit counter range.
  always_comb begin
    dly_prod = 48'(rom_q[15:0]) * 48'(DELAY_UNIT_CYCLES);
    dly_load = (|dly_prod[47:24]) ? 24'hFF_FFFF : dly_prod[23:0];
    active   = (state != S_IDLE) && (state != S_DONE);
    abort    = active && !lcd_rst_done;
  end

  // Sequencer FSM, ROM read register and registered bus outputs.
  always_ff @(posedge clk or posedge reset_tick) begin
    if (reset_tick) begin
      state     <= S_IDLE;
      idx       <= '0;
      rom_q     <= '0;
      cnt       <= '0;
      cs_n_q    <= 1'b1;
      rs_q      <= 1'b1;
      wr_n_q    <= 1'b1;
      data_q    <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else if (abort) begin
      // Panel reset dropped mid-sequence: back to idle, init_done untouched.
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      cs_n_q <= 1'b1;
      rs_q   <= 1'b1;
      wr_n_q <= 1'b1;
      data_q <= '0;
      busy   <= 1'b0;
    end else begin
      wr_n_q <= (state != S_WR_LO);
      case (state)
        S_IDLE: begin
          if (lcd_rst_done) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          rom_q <= rom_entry(idx);
          state <= S_SETUP;
        end
        S_SETUP: begin
          // The last index always terminates so idx can never wrap to 0.
          if ((rom_q[17:16] == T_END) || (idx == IDX_LAST)) begin
            state     <= S_DONE;
            cs_n_q    <= 1'b1;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else if (rom_q[17:16] == T_DELAY) begin
            cs_n_q <= 1'b0;
            cnt    <= dly_load;
            state  <= S_DELAY;
          end else begin
            cs_n_q <= 1'b0;
            rs_q   <= rom_q[16];
            data_q <= rom_q[15:0];
            cnt    <= WR_LO_LOAD;
            state  <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (cnt == '0) begin
            cnt   <= WR_HI_LOAD;
            state <= S_WR_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR_HI, S_DELAY: begin
          if (cnt == '0) begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign lcd.lcd_cs_n = cs_n_q;
  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_wr_n = wr_n_q;
  assign lcd.lcd_rd_n = 1'b1;
  assign lcd.lcd_data = data_q;
  assign state_dbg    = state;

endmodule
